// File: rtl/sparse_selector_nm.sv
// N:M sparse activation selector: gathers the activations at the set bits of a
// shared per-block weight mask, for every group, through a two-stage valid/ready pipeline.
module sparse_selector_nm #(
  parameter int GROUPS = 14,
  parameter int BLOCKS = 2,
  parameter int M      = 8,
  parameter int N      = 4,
  parameter int DW     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BLOCKS*M-1:0]          in_mask,
  input  logic [GROUPS*BLOCKS*M*DW-1:0] in_act,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [GROUPS*BLOCKS*N*DW-1:0] out_act,
  output logic [BLOCKS-1:0]            out_err
);

  localparam int IW  = (M > 1) ? $clog2(M) : 1;
  localparam int IAW = GROUPS * BLOCKS * M * DW;
  localparam int OAW = GROUPS * BLOCKS * N * DW;

  logic                              s1Valid_q;
  logic [BLOCKS-1:0][N-1:0][IW-1:0]  s1Idx_d, s1Idx_q;
  logic [BLOCKS-1:0][N-1:0]          s1Used_d, s1Used_q;
  logic [BLOCKS-1:0]                 s1Err_d, s1Err_q;
  logic [IAW-1:0]                    s1Act_q;

  logic                              outValid_q;
  logic [OAW-1:0]                    outAct_d, outAct_q;
  logic [BLOCKS-1:0]                 outErr_q;

  logic adv2;
  logic inXfer;

  assign adv2     = !outValid_q || out_ready;
  assign in_ready = !s1Valid_q || adv2;
  assign inXfer   = in_valid && in_ready;

  // Slot k takes the position of the k-th set mask bit; cnt counts set bits seen so far.
  always_comb begin
    int cnt;
    s1Idx_d  = '0;
    s1Used_d = '0;
    s1Err_d  = '0;
    cnt      = 0;
    for (int b = 0; b < BLOCKS; b++) begin
      cnt = 0;
      for (int e = 0; e < M; e++) begin
        if (in_mask[b*M+e]) begin
          for (int k = 0; k < N; k++) begin
            if (cnt == k) begin
              s1Idx_d[b][k]  = IW'(e);
              s1Used_d[b][k] = 1'b1;
            end
          end
          cnt = cnt + 1;
        end
      end
      s1Err_d[b] = (cnt > N);
    end
  end

  always_comb begin
    outAct_d = '0;
    for (int g = 0; g < GROUPS; g++) begin
      for (int b = 0; b < BLOCKS; b++) begin
        for (int k = 0; k < N; k++) begin
          for (int e = 0; e < M; e++) begin
            if (s1Used_q[b][k] && (s1Idx_q[b][k] == IW'(e))) begin
              outAct_d[((g*BLOCKS+b)*N+k)*DW +: DW] = s1Act_q[((g*BLOCKS+b)*M+e)*DW +: DW];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Idx_q   <= '0;
      s1Used_q  <= '0;
      s1Err_q   <= '0;
      s1Act_q   <= '0;
    end else if (inXfer) begin
      s1Valid_q <= 1'b1;
      s1Idx_q   <= s1Idx_d;
      s1Used_q  <= s1Used_d;
      s1Err_q   <= s1Err_d;
      s1Act_q   <= in_act;
    end else if (adv2) begin
      s1Valid_q <= 1'b0;
    end
  end

  // S2 only moves when downstream is free, which keeps the output stable during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outAct_q   <= '0;
      outErr_q   <= '0;
    end else if (adv2) begin
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        outAct_q <= outAct_d;
        outErr_q <= s1Err_q;
      end
    end
  end

  assign out_valid = outValid_q;
  assign out_act   = outValid_q ? outAct_q : '0;
  assign out_err   = outValid_q ? outErr_q : '0;

endmodule

// File: tb/tb_sparse_selector_nm.sv
// Self-checking bench for sparse_selector_nm: directed steps plus random beats
// compared against a set-bit-list reference model through an in-order scoreboard.
module tb_sparse_selector_nm;

  localparam int GROUPS = 14;
  localparam int BLOCKS = 2;
  localparam int M      = 8;
  localparam int N      = 4;
  localparam int DW     = 4;
  localparam int IAW    = GROUPS * BLOCKS * M * DW;
  localparam int OAW    = GROUPS * BLOCKS * N * DW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [BLOCKS*M-1:0]  in_mask;
  logic [IAW-1:0]       in_act;
  logic                 out_valid;
  logic                 out_ready;
  logic [OAW-1:0]       out_act;
  logic [BLOCKS-1:0]    out_err;

  int compared   = 0;
  int mismatched = 0;

  logic [BLOCKS+OAW-1:0] sb[$];

  sparse_selector_nm #(.GROUPS(GROUPS), .BLOCKS(BLOCKS), .M(M), .N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask), .in_act(in_act),
    .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Reference: list the set mask positions, fill slots from that list, zero the rest.
  function automatic logic [OAW-1:0] refAct(input logic [BLOCKS*M-1:0] mask, input logic [IAW-1:0] act);
    logic [OAW-1:0] res;
    int pos[$];
    res = '0;
    for (int b = 0; b < BLOCKS; b++) begin
      pos.delete();
      for (int e = 0; e < M; e++) if (mask[b*M+e]) pos.push_back(e);
      for (int g = 0; g < GROUPS; g++)
        for (int k = 0; k < N && k < pos.size(); k++)
          res[((g*BLOCKS+b)*N+k)*DW +: DW] = act[((g*BLOCKS+b)*M+pos[k])*DW +: DW];
    end
    return res;
  endfunction

  function automatic logic [BLOCKS-1:0] refErr(input logic [BLOCKS*M-1:0] mask);
    logic [BLOCKS-1:0] res;
    logic [M-1:0] blk;
    for (int b = 0; b < BLOCKS; b++) begin
      blk    = mask[b*M +: M];
      res[b] = ($countones(blk) > N);
    end
    return res;
  endfunction

  function automatic logic [IAW-1:0] randAct();
    logic [IAW-1:0] a;
    for (int i = 0; i < IAW/32; i++) a[i*32 +: 32] = $urandom;
    return a;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score any output transfer, record any input transfer, then advance.
  task automatic step();
    logic [BLOCKS+OAW-1:0] exp;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) check("spuriousOut", {511'd0, out_valid}, 512'd0);
      else begin
        exp = sb.pop_front();
        check("outAct", out_act, exp[OAW-1:0]);
        check("outErr", out_err, exp[BLOCKS+OAW-1:OAW]);
      end
    end
    if (in_valid && in_ready) sb.push_back({refErr(in_mask), refAct(in_mask, in_act)});
    @(posedge clk);
    #1;
    if (!out_valid) check("idleZero", {out_err, out_act}, 512'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      step();
      n++;
    end
    check("drainDone", sb.size(), 512'd0);
  endtask

  logic [IAW-1:0]      actA[4];
  logic [BLOCKS*M-1:0] maskA[4];
  logic [OAW-1:0]      firstRef;
  int                  acc;
  logic                wasXfer;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mask = '0; in_act = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rstInReady", in_ready, 1);
    check("rstOutValid", out_valid, 0);
    check("rstOutAct", {out_err, out_act}, 0);

    // Mixed-density mask, latency of exactly two cycles
    in_act = randAct();
    in_act[31:0] = 32'h76543210;
    in_mask = {8'h0F, 8'hA5};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat1", out_valid, 0);
    step();
    check("lat2", out_valid, 1);
    check("g0b0", out_act[15:0], 16'h7520);
    check("errNone", out_err, 2'b00);
    drain();

    // Over-populated block 0 and sparse block 1
    in_act = randAct();
    in_act[63:0] = 64'hFEDCBA98_76543210;
    in_mask = {8'h81, 8'hFF};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("fullB0", out_act[15:0], 16'h3210);
    check("sparseB1", out_act[31:16], 16'h00F8);
    check("errB0", out_err, 2'b01);
    drain();

    // Empty mask still produces a valid all-zero beat
    in_act = randAct();
    in_mask = '0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("emptyValid", out_valid, 1);
    check("emptyAct", out_act, 0);
    check("emptyErr", out_err, 0);
    drain();

    // Backpressure: four beats offered, downstream stalled for five cycles
    for (int i = 0; i < 4; i++) begin
      actA[i]  = randAct();
      maskA[i] = 16'($urandom);
    end
    firstRef = refAct(maskA[0], actA[0]);
    acc = 0;
    out_ready = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      in_valid = 1'b1;
      in_mask  = maskA[acc];
      in_act   = actA[acc];
      #1;
      check("bpInReady", in_ready, (cyc <= 2) ? 1 : 0);
      if (cyc >= 3) begin
        check("bpHoldValid", out_valid, 1);
        check("bpHoldAct", out_act, firstRef);
      end
      wasXfer = in_valid && in_ready;
      step();
      if (wasXfer) acc++;
    end
    check("bpAccepted", acc, 2);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (acc < 4) begin
        in_valid = 1'b1;
        in_mask  = maskA[acc];
        in_act   = actA[acc];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("bpStream", out_valid, 1);
      wasXfer = in_valid && in_ready;
      step();
      if (wasXfer) acc++;
    end
    in_valid = 1'b0;
    check("bpAllIn", acc, 4);
    drain();

    // Back-to-back random stream
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_mask  = 16'($urandom);
      in_act   = randAct();
      #1;
      check("streamReady", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    drain();

    // Reset with both stages occupied
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_mask  = 16'($urandom);
      in_act   = randAct();
      step();
    end
    check("preRstValid", out_valid, 1);
    rst = 1'b1;
    in_mask = 16'hFFFF;
    in_act = randAct();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    #1;
    check("postRstValid", out_valid, 0);
    check("postRstAct", out_act, 0);
    check("postRstReady", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("noStale", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
